// File: rtl/regfile_pkg.sv
// Shared sizing defaults and FSM state encoding for the clearable register file.
package regfile_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned ADDR_WIDTH = 5;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StClear = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_clr_if.sv
// Register-file access bus: two read ports, one write port, clear request and status.
interface regfile_clr_if #(
  parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] ReadRegister1;
  logic [ADDR_WIDTH-1:0] ReadRegister2;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  RegWrite;
  logic                  Clear;
  logic                  Busy;
  logic                  WriteDropped;

  modport master (
    output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite, Clear,
    input  ReadData1, ReadData2, Busy, WriteDropped
  );

  modport slave (
    input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite, Clear,
    output ReadData1, ReadData2, Busy, WriteDropped
  );

endinterface

// File: rtl/regarray.sv
// Storage for registers 1..RegCount-1 with a one-hot decoded write port and two read muxes.
module regarray #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned RegCount  = 32,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr1_i,
  input  logic [AddrWidth-1:0] raddr2_i,
  output logic [DataWidth-1:0] rdata1_o,
  output logic [DataWidth-1:0] rdata2_o
);

  // Register 0 has no storage; it is hardwired to zero on both read ports.
  logic [DataWidth-1:0] mem_q [1:RegCount-1];
  logic [RegCount-1:0]  we_onehot;

  always_comb begin
    we_onehot = '0;
    for (int unsigned i = 1; i < RegCount; i++) begin
      if (we_i && (waddr_i == AddrWidth'(i))) begin
        we_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 1; i < RegCount; i++) begin
      if (we_onehot[i]) begin
        mem_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    for (int unsigned i = 1; i < RegCount; i++) begin
      if (raddr1_i == AddrWidth'(i)) begin
        rdata1_o = mem_q[i];
      end
      if (raddr2_i == AddrWidth'(i)) begin
        rdata2_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/regfile_clr.sv
// Two-read/one-write register file with a sequential clear FSM that zeros one register per cycle.
module regfile_clr
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int unsigned REG_COUNT  = regfile_pkg::REG_COUNT,
  parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input logic          Clk,
  input logic          Reset,
  regfile_clr_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] FirstIdx = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(REG_COUNT - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clr_idx_q;
  logic                  write_dropped_q;

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  write_rejected;

  assign busy = (state_q == StClear);

  // A write to r0 is discarded silently, so it never counts as rejected.
  assign write_rejected = bus.RegWrite && (bus.WriteRegister != '0) && (busy || bus.Clear);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q         <= StClear;
      clr_idx_q       <= FirstIdx;
      write_dropped_q <= 1'b0;
    end else begin
      write_dropped_q <= write_rejected;
      case (state_q)
        StIdle: begin
          if (bus.Clear) begin
            state_q   <= StClear;
            clr_idx_q <= FirstIdx;
          end
        end
        StClear: begin
          // Index stops at the last register rather than wrapping.
          if (clr_idx_q == LastIdx) begin
            state_q <= StIdle;
          end else begin
            clr_idx_q <= clr_idx_q + FirstIdx;
          end
        end
      endcase
    end
  end

  // The clear sequence borrows the single write port; user writes only land in idle.
  always_comb begin
    we    = 1'b0;
    waddr = bus.WriteRegister;
    wdata = bus.WriteData;
    if (!Reset) begin
      if (busy) begin
        we    = 1'b1;
        waddr = clr_idx_q;
        wdata = '0;
      end else if (!bus.Clear) begin
        we = bus.RegWrite;
      end
    end
  end

  regarray #(
    .DataWidth(DATA_WIDTH),
    .RegCount (REG_COUNT),
    .AddrWidth(ADDR_WIDTH)
  ) u_regarray (
    .clk_i   (Clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr1_i(bus.ReadRegister1),
    .raddr2_i(bus.ReadRegister2),
    .rdata1_o(bus.ReadData1),
    .rdata2_o(bus.ReadData2)
  );

  assign bus.Busy         = busy;
  assign bus.WriteDropped = write_dropped_q;

endmodule

// File: tb/tb_regfile_clr.sv
// Directed bench for regfile_clr: reset clear, writes, r0, full map, clear, busy writes, reset.
module tb_regfile_clr;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;
  int   n;

  regfile_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  regfile_clr #(
    .DATA_WIDTH(32),
    .REG_COUNT (32),
    .ADDR_WIDTH(5)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mapv(input int i);
    return (i == 0) ? 32'd0 : 32'(i + 100);
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    bus.ReadRegister1 = '0;
    bus.ReadRegister2 = '0;
    bus.WriteRegister = 5'd3;
    bus.WriteData     = 32'd5;
    bus.RegWrite      = 1'b1;
    bus.Clear         = 1'b0;

    // Reset with a write presented: write dropped, no WriteDropped pulse.
    tick();
    tick();
    chk("reset_busy", bus.Busy, 1'b1);
    chk("reset_wd", bus.WriteDropped, 1'b0);
    Reset = 1'b0;
    bus.RegWrite = 1'b0;
    n = 0;
    while (bus.Busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("reset_busy_len", n, 31);
    bus.ReadRegister1 = 5'd3;
    #1;
    chk("reset_r3_zero", bus.ReadData1, 32'd0);

    // Write enable: first write after idle accepted, RegWrite=0 ignored.
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd2; bus.WriteData = 32'd15;
    tick();
    bus.RegWrite = 1'b0; bus.WriteData = 32'd16;
    tick();
    bus.ReadRegister1 = 5'd2; bus.ReadRegister2 = 5'd2;
    #1;
    chk("we_rd1", bus.ReadData1, 32'd15);
    chk("we_rd2", bus.ReadData2, 32'd15);

    // No write bypass: data visible only after the edge.
    bus.ReadRegister1 = 5'd4;
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd4; bus.WriteData = 32'd77;
    #1;
    chk("nobypass_before", bus.ReadData1, 32'd0);
    tick();
    bus.RegWrite = 1'b0;
    chk("nobypass_after", bus.ReadData1, 32'd77);

    // Register zero.
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd0; bus.WriteData = 32'hFFFF_FFFF;
    tick();
    bus.RegWrite = 1'b0;
    bus.ReadRegister1 = 5'd0;
    #1;
    chk("r0_read", bus.ReadData1, 32'd0);
    chk("r0_wd", bus.WriteDropped, 1'b0);

    // Full map through both ports.
    for (int i = 1; i < 32; i++) begin
      bus.RegWrite = 1'b1; bus.WriteRegister = 5'(i); bus.WriteData = 32'(i + 100);
      tick();
    end
    bus.RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.ReadRegister1 = 5'(i);
      bus.ReadRegister2 = 5'(31 - i);
      #1;
      chk("map_rd1", bus.ReadData1, mapv(i));
      chk("map_rd2", bus.ReadData2, mapv(31 - i));
    end

    // Clear with a simultaneous write: clear wins, write dropped.
    bus.Clear = 1'b1; bus.RegWrite = 1'b1; bus.WriteRegister = 5'd9; bus.WriteData = 32'd999;
    tick();
    chk("clr_busy", bus.Busy, 1'b1);
    chk("clr_collide_wd", bus.WriteDropped, 1'b1);
    bus.Clear = 1'b0; bus.RegWrite = 1'b0;
    tick();
    chk("clr_wd_one_cycle", bus.WriteDropped, 1'b0);
    tick();
    // Third CLEAR cycle: write to r7 and a redundant Clear, both ignored.
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd7; bus.WriteData = 32'd42; bus.Clear = 1'b1;
    bus.ReadRegister1 = 5'd5;
    #1;
    chk("clr_r5_old", bus.ReadData1, 32'd105);
    tick();
    chk("busy_wr_wd", bus.WriteDropped, 1'b1);
    bus.RegWrite = 1'b0; bus.Clear = 1'b0;
    tick();
    chk("busy_wr_wd_end", bus.WriteDropped, 1'b0);
    chk("clr_r5_pre", bus.ReadData1, 32'd105);
    tick();
    chk("clr_r5_edge5", bus.ReadData1, 32'd0);
    bus.ReadRegister2 = 5'd6;
    #1;
    chk("clr_r6_old", bus.ReadData2, 32'd106);
    bus.ReadRegister1 = 5'd9;
    #1;
    chk("clr_r9_kept", bus.ReadData1, 32'd109);
    n = 5;
    while (bus.Busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("clr_busy_len", n, 31);
    chk("clr_idle_wd", bus.WriteDropped, 1'b0);
    for (int i = 0; i < 32; i++) begin
      bus.ReadRegister1 = 5'(i);
      bus.ReadRegister2 = 5'(i);
      #1;
      chk("clr_all_rd1", bus.ReadData1, 32'd0);
      chk("clr_all_rd2", bus.ReadData2, 32'd0);
    end

    // Reset in CLEAR cycle 10 restarts the sequence.
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd4; bus.WriteData = 32'd44;
    tick();
    bus.RegWrite = 1'b0;
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    repeat (9) tick();
    Reset = 1'b1;
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd12; bus.WriteData = 32'd1;
    tick();
    chk("rst_mid_busy", bus.Busy, 1'b1);
    chk("rst_mid_wd", bus.WriteDropped, 1'b0);
    Reset = 1'b0;
    bus.RegWrite = 1'b0;
    n = 0;
    while (bus.Busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("rst_mid_busy_len", n, 31);
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd12; bus.WriteData = 32'd55;
    tick();
    bus.RegWrite = 1'b0;
    bus.ReadRegister1 = 5'd12; bus.ReadRegister2 = 5'd4;
    #1;
    chk("rst_mid_write", bus.ReadData1, 32'd55);
    chk("rst_mid_r4_zero", bus.ReadData2, 32'd0);
    chk("rst_mid_wd_end", bus.WriteDropped, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
